// File: rtl/led_pkg.sv
// Shared definitions for the LED mode sequencer.
//   mode_e       : LED pattern mode encoding (OFF, ON, SLOW blink, FAST blink)
//   DEF_*        : default timing constants in clk cycles
//   next_mode()  : mode sequence step, wraps FAST -> OFF
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20;
  localparam int unsigned DEF_SLOW_HALF       = 50;
  localparam int unsigned DEF_FAST_HALF       = 10;

  function automatic mode_e next_mode(input mode_e m);
    logic [1:0] v;
    v = m;
    v = v + 2'd1;
    return mode_e'(v);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-level debounce and a
// one-cycle press pulse on each accepted 1->0 transition of the debounced key.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   key_in    : raw active-low push-button, asynchronous to clk
//   key_press : registered one-cycle pulse per accepted press
module key_debounce
  import led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          key_s_q, key_s_d;
  logic          key_db_q, key_db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_press_q, key_press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      key_s_q     <= 1'b1;
      key_db_q    <= 1'b1;
      cnt_q       <= '0;
      key_press_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      key_s_q     <= key_s_d;
      key_db_q    <= key_db_d;
      cnt_q       <= cnt_d;
      key_press_q <= key_press_d;
    end
  end

  always_comb begin
    sync1_d  = key_in;
    key_s_d  = sync1_q;
    key_db_d = key_db_q;
    cnt_d    = '0;
    // Count consecutive mismatch cycles; any agreement restarts the count.
    if (key_s_q != key_db_q) begin
      if (cnt_q == CNT_LAST) begin
        key_db_d = key_s_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    key_press_d = key_db_q & ~key_db_d;
  end

  assign key_press = key_press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED sequencer: each debounced key press steps the mode OFF->ON->SLOW->FAST,
// blink modes toggle a phase bit every HALF cycles, and the registered output
// applies a (enable) and b (invert).
//   clk, rst_n : clock, asynchronous active-low reset
//   a          : output enable (0 forces led_out low)
//   b          : output invert
//   key_in     : raw active-low push-button
//   led_out    : registered LED drive
//   mode       : current mode (0=OFF 1=ON 2=SLOW 3=FAST)
//   key_press  : one-cycle pulse per accepted press
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SLOW_HALF       = DEF_SLOW_HALF,
  parameter int unsigned FAST_HALF       = DEF_FAST_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       key_press
);

  localparam int unsigned BW = $clog2(SLOW_HALF);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

  logic          key_press_w;
  mode_e         mode_q, mode_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          led_out_q, led_out_d;
  logic          pattern;
  logic [BW-1:0] half_last;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_press(key_press_w)
  );

  // State register plus blink and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_out_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_out_q   <= led_out_d;
    end
  end

  // Next-state logic.
  always_comb begin
    mode_d = mode_q;
    if (key_press_w) begin
      mode_d = next_mode(mode_q);
    end
  end

  // Output logic: blink generator, pattern and output stage.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b1;
    half_last   = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;
    // A pending mode change keeps the defaults (count 0, phase 1), overriding
    // any wrap/toggle due in the same cycle.
    if ((mode_d == mode_q) && ((mode_q == MODE_SLOW) || (mode_q == MODE_FAST))) begin
      if (blink_cnt_q == half_last) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
      end
    end

    pattern = 1'b0;
    unique case (mode_q)
      MODE_OFF:  pattern = 1'b0;
      MODE_ON:   pattern = 1'b1;
      MODE_SLOW: pattern = phase_q;
      MODE_FAST: pattern = phase_q;
    endcase
    led_out_d = a & (pattern ^ b);
  end

  assign led_out   = led_out_q;
  assign mode      = mode_q;
  assign key_press = key_press_w;

endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, key_in;
  logic       led_out;
  logic [1:0] mode;
  logic       key_press;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(20),
    .SLOW_HALF      (50),
    .FAST_HALF      (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .key_in   (key_in),
    .led_out  (led_out),
    .mode     (mode),
    .key_press(key_press)
  );

  typedef struct {
    int         low;
    int         exp_pulses;
    logic [1:0] exp_mode;
  } press_vec_t;

  typedef struct {
    logic [1:0] mode;
    logic       a;
    logic       b;
    logic       exp_led;
  } ab_vec_t;

  press_vec_t pv[7];
  ab_vec_t    av[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold key low for low_cyc clocks then released for 40, counting key_press.
  task automatic press(input int low_cyc, output int highs, output int rises);
    logic prev;
    highs = 0;
    rises = 0;
    prev  = 1'b0;
    key_in = 1'b0;
    repeat (low_cyc) begin
      @(negedge clk);
      if (key_press === 1'b1) begin
        highs++;
        if (!prev) rises++;
      end
      prev = key_press;
    end
    key_in = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (key_press === 1'b1) begin
        highs++;
        if (!prev) rises++;
      end
      prev = key_press;
    end
  endtask

  task automatic goto_mode(input logic [1:0] target);
    int h, r;
    for (int k = 0; k < 5 && mode !== target; k++) press(40, h, r);
    check("goto_mode", mode, target);
  endtask

  task automatic count_pulses(input int cyc, output int highs);
    highs = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (key_press === 1'b1) highs++;
    end
  endtask

  task automatic measure_run(input logic level, output int n);
    n = 0;
    while (led_out === level && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int h, r, n, t;
    logic prev;

    pv[0] = '{40, 1, 2'd2};
    pv[1] = '{40, 1, 2'd3};
    pv[2] = '{40, 1, 2'd0};
    pv[3] = '{5,  0, 2'd0};
    pv[4] = '{19, 0, 2'd0};
    pv[5] = '{20, 1, 2'd1};
    pv[6] = '{25, 1, 2'd2};

    av[0] = '{2'd0, 1'b1, 1'b1, 1'b1};
    av[1] = '{2'd0, 1'b0, 1'b1, 1'b0};
    av[2] = '{2'd0, 1'b1, 1'b0, 1'b0};
    av[3] = '{2'd0, 1'b1, 1'b1, 1'b1};
    av[4] = '{2'd1, 1'b1, 1'b1, 1'b0};
    av[5] = '{2'd1, 1'b1, 1'b0, 1'b1};
    av[6] = '{2'd1, 1'b0, 1'b1, 1'b0};
    av[7] = '{2'd1, 1'b0, 1'b0, 1'b0};
    av[8] = '{2'd2, 1'b0, 1'b0, 1'b0};
    av[9] = '{2'd2, 1'b0, 1'b1, 1'b0};

    // Reset
    rst_n = 1'b0; key_in = 1'b1; a = 1'b1; b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", led_out, 0);
    check("rst_mode", mode, 0);
    check("rst_key_press", key_press, 0);
    rst_n = 1'b1;
    count_pulses(200, h);
    check("idle_pulses", h, 0);
    check("idle_mode", mode, 0);
    check("idle_led", led_out, 0);

    // First press: led follows mode one cycle later
    key_in = 1'b0;
    t = 0;
    while (mode !== 2'd1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("press1_mode", mode, 1);
    check("press1_led_before", led_out, 0);
    @(negedge clk);
    check("press1_led_after", led_out, 1);
    key_in = 1'b1;
    repeat (40) @(negedge clk);

    // Press sequencing and glitch rejection
    for (int i = 0; i < 7; i++) begin
      press(pv[i].low, h, r);
      check($sformatf("press_highs_%0d", i), h, pv[i].exp_pulses);
      check($sformatf("press_rises_%0d", i), r, pv[i].exp_pulses);
      check($sformatf("press_mode_%0d", i), mode, pv[i].exp_mode);
    end

    // SLOW blink: align to a rising edge of led_out
    prev = led_out;
    t = 0;
    @(negedge clk);
    while (!(led_out === 1'b1 && prev === 1'b0) && t < 150) begin
      prev = led_out;
      @(negedge clk);
      t++;
    end
    check("slow_rise_seen", (t < 150), 1);
    measure_run(1'b1, n);
    check("slow_high", n, 50);
    measure_run(1'b0, n);
    check("slow_low", n, 50);

    // FAST blink: first half high right after the mode change
    key_in = 1'b0;
    t = 0;
    while (mode !== 2'd3 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("fast_mode", mode, 3);
    key_in = 1'b1;
    @(negedge clk);
    check("fast_first_half", led_out, 1);
    measure_run(1'b1, n);
    check("fast_high", n, 10);
    measure_run(1'b0, n);
    check("fast_low", n, 10);
    measure_run(1'b1, n);
    check("fast_high2", n, 10);

    // Enable / invert table
    for (int i = 0; i < 10; i++) begin
      goto_mode(av[i].mode);
      a = av[i].a;
      b = av[i].b;
      @(negedge clk);
      check($sformatf("ab_led_%0d", i), led_out, av[i].exp_led);
    end

    // Reset mid-blink
    a = 1'b1; b = 1'b0;
    t = 0;
    while (led_out !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("midblink_led_on", led_out, 1);
    check("midblink_mode", mode, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", led_out, 0);
    check("async_rst_mode", mode, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_pulses(100, h);
    check("post_rst_pulses", h, 0);
    press(15, h, r);
    check("post_rst_short", h, 0);
    check("post_rst_short_mode", mode, 0);
    press(20, h, r);
    check("post_rst_press", h, 1);
    check("post_rst_press_mode", mode, 1);

    // Key held low through reset release
    key_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("held_rst_mode", mode, 0);
    rst_n = 1'b1;
    count_pulses(60, h);
    check("held_press_pulses", h, 1);
    check("held_press_mode", mode, 1);
    key_in = 1'b1;
    count_pulses(40, h);
    check("held_release_pulses", h, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
